chan_err_inject: RTL and testbench

// - Channel-model stage between encoder2 (d_out/valid_o) and decoder (d_in/enable) in the Viterbi tx/rx chain.
// - Corrupts encoded 2-bit symbols under programmable control: pass, periodic burst, or LFSR-random.
// - Counts injected bit and symbol errors and stops injecting once an optional error budget is used up.
// - Registered stage with 1-cycle latency. Its outputs drive the decoder directly.

---
 rtl/viterbi_pkg.sv | 23 ++
 rtl/lfsr16.sv | 44 ++++
 rtl/chan_err_inject.sv | 184 ++++++++++++++++++
 tb/tb_chan_err_inject.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi tx/rx chain.
//   inj_mode_t  : channel error-injection mode selector
//   inj_state_t : periodic-burst injector phase
//   LFSR_TAPS   : feedback taps of the 16-bit channel LFSR
package viterbi_pkg;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_RANDOM   = 2'd2,
    MODE_RSVD     = 2'd3
  } inj_mode_t;

  typedef enum logic {
    S_GAP   = 1'b0,
    S_BURST = 1'b1
  } inj_state_t;

  // x^16 + x^14 + x^13 + x^11 + 1 for a right-shifting Fibonacci register:
  // the feedback is the XOR of bits 0, 2, 3 and 5, shifted into bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (right shift) with synchronous reseed.
// Ports:
//   clk, rst (async, active-low) -- reset loads SEED
//   step   : advance one position
//   reseed : load SEED (wins over step)
//   q      : low Q_W bits of the register
module lfsr16
  import viterbi_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int          Q_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           step,
  input  logic           reseed,
  output logic [Q_W-1:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  always_comb begin
    fb     = ^(lfsr_q & LFSR_TAPS);
    lfsr_d = lfsr_q;
    if (reseed) begin
      lfsr_d = SEED;
    end else if (step) begin
      lfsr_d = {fb, lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q[Q_W-1:0];

endmodule

// File: rtl/chan_err_inject.sv
// Channel-model stage between the convolutional encoder and the Viterbi
// decoder. Corrupts 2-bit symbols (pass / periodic burst / LFSR random),
// counts injected bit and symbol errors and stops once the budget is used.
// Ports:
//   clk, rst (async, active-low)
//   valid_i, sym_i            : encoded symbol stream in
//   mode_i, gap_len_i, burst_len_i, err_mask_i, thresh_i, max_err_i : control
//   clr_i                     : synchronous clear of counters, FSM and LFSR
//   valid_o, sym_o, err_o     : registered stream out (1-cycle latency)
//   bit_err_ct_o, sym_err_ct_o: saturating error counters
//   budget_o                  : error budget exhausted
//   dbg_state_o               : periodic injector phase
// Handshake: valid_i qualifies sym_i for one cycle; there is no back-pressure,
// every valid symbol is accepted and reappears with valid_o one cycle later.
module chan_err_inject
  import viterbi_pkg::*;
#(
  parameter int          SYM_W = 2,
  parameter int          CNT_W = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [SYM_W-1:0] sym_i,
  input  logic [1:0]       mode_i,
  input  logic [7:0]       gap_len_i,
  input  logic [3:0]       burst_len_i,
  input  logic [SYM_W-1:0] err_mask_i,
  input  logic [7:0]       thresh_i,
  input  logic [CNT_W-1:0] max_err_i,
  input  logic             clr_i,
  output logic             valid_o,
  output logic [SYM_W-1:0] sym_o,
  output logic [SYM_W-1:0] err_o,
  output logic [CNT_W-1:0] bit_err_ct_o,
  output logic [CNT_W-1:0] sym_err_ct_o,
  output logic             budget_o,
  output inj_state_t       dbg_state_o
);

  if (SEED == 16'h0000) begin : g_seed_zero
    $error("chan_err_inject: SEED must be nonzero");
  end

  inj_state_t       state_q, state_d, cur_state;
  inj_mode_t        mode_q, mode_d, mode_in;
  logic [7:0]       cnt_q, cnt_d, cur_cnt, cnt_inc, burst_w;
  logic [7:0]       lfsr_lo;
  logic             mode_chg, hit;
  logic [SYM_W-1:0] err_d;
  logic [CNT_W:0]   pop, bit_sum, sym_sum;
  logic [CNT_W-1:0] bit_ct_q, bit_ct_d, sym_ct_q, sym_ct_d;
  logic             budget_q, budget_d;
  logic             valid_q;
  logic [SYM_W-1:0] sym_q, err_q;

  lfsr16 #(.SEED(SEED), .Q_W(8)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .step   (valid_i),
    .reseed (clr_i),
    .q      (lfsr_lo)
  );

  assign mode_in = inj_mode_t'(mode_i);

  always_comb begin
    // A mode change restarts the periodic pattern with the current symbol.
    mode_chg  = (mode_in != mode_q);
    cur_state = mode_chg ? S_GAP : state_q;
    cur_cnt   = mode_chg ? 8'd0 : cnt_q;
    cnt_inc   = cur_cnt + 8'd1;
    burst_w   = {4'd0, burst_len_i};
    hit       = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    if (valid_i) begin
      mode_d  = mode_in;
      state_d = S_GAP;
      cnt_d   = '0;
      case (mode_in)
        MODE_RANDOM: hit = (lfsr_lo < thresh_i);
        MODE_PERIODIC: begin
          state_d = cur_state;
          cnt_d   = cur_cnt;
          if (cur_state == S_GAP) begin
            if (burst_len_i == 4'd0) begin
              cnt_d = '0;
            end else if (cur_cnt >= gap_len_i) begin
              // Gap already complete (gap_len_i=0 or shortened live):
              // this symbol is the first of the burst.
              hit = 1'b1;
              if (burst_w > 8'd1) begin
                state_d = S_BURST;
                cnt_d   = 8'd1;
              end else begin
                cnt_d = '0;
              end
            end else if (cnt_inc >= gap_len_i) begin
              state_d = S_BURST;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            if (burst_len_i == 4'd0) begin
              state_d = S_GAP;
              cnt_d   = '0;
            end else begin
              hit = 1'b1;
              if (cnt_inc >= burst_w) begin
                state_d = S_GAP;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_inc;
              end
            end
          end
        end
        default: hit = 1'b0;
      endcase
    end

    err_d = (hit && !budget_q && !clr_i) ? err_mask_i : '0;

    pop = '0;
    for (int i = 0; i < SYM_W; i++) begin
      pop = pop + {{CNT_W{1'b0}}, err_d[i]};
    end
    bit_sum  = {1'b0, bit_ct_q} + pop;
    sym_sum  = {1'b0, sym_ct_q} + {{CNT_W{1'b0}}, |err_d};
    bit_ct_d = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    sym_ct_d = sym_sum[CNT_W] ? '1 : sym_sum[CNT_W-1:0];

    // Budget flag rises together with the count that reaches max_err_i.
    budget_d = budget_q;
    if (valid_i) begin
      budget_d = (max_err_i != '0) && (sym_ct_d >= max_err_i);
    end

    if (clr_i) begin
      state_d  = S_GAP;
      cnt_d    = '0;
      bit_ct_d = '0;
      sym_ct_d = '0;
      budget_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_GAP;
      cnt_q    <= '0;
      mode_q   <= MODE_PASS;
      bit_ct_q <= '0;
      sym_ct_q <= '0;
      budget_q <= 1'b0;
      valid_q  <= 1'b0;
      sym_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      bit_ct_q <= bit_ct_d;
      sym_ct_q <= sym_ct_d;
      budget_q <= budget_d;
      valid_q  <= valid_i;
      sym_q    <= sym_i ^ err_d;
      err_q    <= err_d;
    end
  end

  assign valid_o      = valid_q;
  assign sym_o        = sym_q;
  assign err_o        = err_q;
  assign bit_err_ct_o = bit_ct_q;
  assign sym_err_ct_o = sym_ct_q;
  assign budget_o     = budget_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_chan_err_inject.sv
module tb_chan_err_inject;
  import viterbi_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        valid_i, clr_i;
  logic [1:0]  sym_i, mode_i, err_mask_i;
  logic [7:0]  gap_len_i, thresh_i;
  logic [3:0]  burst_len_i;
  logic [15:0] max_err_i;
  logic        valid_o, budget_o;
  logic [1:0]  sym_o, err_o;
  logic [15:0] bit_err_ct_o, sym_err_ct_o;
  inj_state_t  dbg_state_o;

  // narrow-counter instance used for the saturation check
  logic [3:0]  max_err_s;
  logic        s_valid_o, s_budget_o;
  logic [1:0]  s_sym_o, s_err_o;
  logic [3:0]  s_bit_ct, s_sym_ct;
  inj_state_t  s_dbg_state;

  chan_err_inject #(.SYM_W(2), .CNT_W(16), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i),
    .gap_len_i(gap_len_i), .burst_len_i(burst_len_i), .err_mask_i(err_mask_i),
    .thresh_i(thresh_i), .max_err_i(max_err_i), .clr_i(clr_i),
    .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o), .bit_err_ct_o(bit_err_ct_o),
    .sym_err_ct_o(sym_err_ct_o), .budget_o(budget_o), .dbg_state_o(dbg_state_o)
  );

  chan_err_inject #(.SYM_W(2), .CNT_W(4), .SEED(SEED)) dut_sat (
    .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i),
    .gap_len_i(gap_len_i), .burst_len_i(burst_len_i), .err_mask_i(err_mask_i),
    .thresh_i(thresh_i), .max_err_i(max_err_s), .clr_i(clr_i),
    .valid_o(s_valid_o), .sym_o(s_sym_o), .err_o(s_err_o), .bit_err_ct_o(s_bit_ct),
    .sym_err_ct_o(s_sym_ct), .budget_o(s_budget_o), .dbg_state_o(s_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] exp_q[$];   // {valid, err, sym} expected one cycle later

  // reference model state: symbol index inside the periodic run, LFSR, counts
  int          m_idx, m_bit, m_sym;
  logic [15:0] m_lfsr;
  bit          m_budget;
  logic [1:0]  m_mode_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] b;
    b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'd1;
    return (s >> 1) | (b << 15);
  endfunction

  function automatic void model_reset();
    m_idx = 0; m_bit = 0; m_sym = 0; m_lfsr = SEED; m_budget = 0; m_mode_prev = 2'd0;
  endfunction

  // Computes what the DUT must show after the coming clock edge.
  function automatic void model_step();
    logic [1:0] e;
    bit         hit;
    int         period;
    e = 2'b00;
    hit = 0;
    if (clr_i) begin
      m_idx = 0; m_bit = 0; m_sym = 0; m_budget = 0; m_lfsr = SEED;
      if (valid_i) m_mode_prev = mode_i;
    end else if (valid_i) begin
      if (mode_i != m_mode_prev) m_idx = 0;
      m_mode_prev = mode_i;
      if (mode_i == 2'd1) begin
        period = int'(gap_len_i) + int'(burst_len_i);
        if (burst_len_i != 0) hit = (m_idx % period) >= int'(gap_len_i);
        m_idx++;
      end else if (mode_i == 2'd2) begin
        hit = int'(m_lfsr & 16'h00FF) < int'(thresh_i);
      end
      m_lfsr = lfsr_next(m_lfsr);
      if (hit && !m_budget) e = err_mask_i;
      m_bit = m_bit + $countones(e);
      if (m_bit > 65535) m_bit = 65535;
      m_sym = m_sym + ((e != 0) ? 1 : 0);
      if (m_sym > 65535) m_sym = 65535;
      m_budget = (max_err_i != 0) && (m_sym >= int'(max_err_i));
    end
    exp_q.push_back({valid_i, e, sym_i ^ e});
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit v, input logic [1:0] s, input bit c);
    logic [4:0] e;
    valid_i = v;
    sym_i   = s;
    clr_i   = c;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("valid_o", 32'(valid_o), 32'(e[4]));
    check("err_o", 32'(err_o), 32'(e[3:2]));
    check("sym_o", 32'(sym_o), 32'(e[1:0]));
    check("bit_err_ct", 32'(bit_err_ct_o), 32'(m_bit));
    check("sym_err_ct", 32'(sym_err_ct_o), 32'(m_sym));
    check("budget_o", 32'(budget_o), 32'(m_budget));
  endtask

  task automatic set_ctl(input logic [1:0] md, input logic [7:0] g, input logic [3:0] b,
                         input logic [1:0] mk, input logic [7:0] th, input logic [15:0] mx);
    mode_i = md; gap_len_i = g; burst_len_i = b; err_mask_i = mk; thresh_i = th; max_err_i = mx;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  gap;
    logic [3:0]  burst;
    logic [1:0]  mask;
    logic [7:0]  thresh;
    logic [15:0] maxe;
    int          nsym;
    bit          idle;
    int          exp_bit;
    int          exp_sym;
    bit          exp_budget;
    bit          chk_hits;
    logic [31:0] exp_hits;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] hits;
    int          k;
    vecs[0] = '{2'd0, 8'd0, 4'd0, 2'b11, 8'hFF, 16'd0, 300, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{2'd1, 8'd3, 4'd2, 2'b01, 8'h00, 16'd0, 20, 1'b0, 8, 8, 1'b0, 1'b1, 32'h000C_6318};
    vecs[2] = '{2'd1, 8'd3, 4'd2, 2'b01, 8'h00, 16'd0, 20, 1'b1, 8, 8, 1'b0, 1'b1, 32'h000C_6318};
    vecs[3] = '{2'd1, 8'd0, 4'd1, 2'b11, 8'h00, 16'd5, 10, 1'b0, 10, 5, 1'b1, 1'b1, 32'h0000_001F};
    vecs[4] = '{2'd2, 8'd0, 4'd0, 2'b11, 8'h00, 16'd0, 200, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{2'd1, 8'd0, 4'd3, 2'b10, 8'h00, 16'd0, 12, 1'b1, 12, 12, 1'b0, 1'b1, 32'h0000_0FFF};
    vecs[6] = '{2'd1, 8'd4, 4'd0, 2'b11, 8'h00, 16'd0, 15, 1'b0, 0, 0, 1'b0, 1'b1, 32'h0};
    vecs[7] = '{2'd1, 8'd1, 4'd2, 2'b00, 8'h00, 16'd0, 9, 1'b0, 0, 0, 1'b0, 1'b1, 32'h0};
    vecs[8] = '{2'd1, 8'd2, 4'd1, 2'b11, 8'h00, 16'd2, 12, 1'b0, 4, 2, 1'b1, 1'b1, 32'h0000_0024};

    // reset
    rst = 1'b0; valid_i = 0; clr_i = 0; sym_i = 0; max_err_s = 4'd0;
    set_ctl(2'd0, 8'd0, 4'd0, 2'b00, 8'd0, 16'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_sym_o", 32'(sym_o), 32'd0);
    check("rst_err_o", 32'(err_o), 32'd0);
    check("rst_bit_ct", 32'(bit_err_ct_o), 32'd0);
    check("rst_sym_ct", 32'(sym_err_ct_o), 32'd0);
    check("rst_budget", 32'(budget_o), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(S_GAP));
    rst = 1'b1;

    // table-driven vectors, each preceded by a clear
    for (int i = 0; i < 9; i++) begin
      set_ctl(vecs[i].mode, vecs[i].gap, vecs[i].burst, vecs[i].mask, vecs[i].thresh, vecs[i].maxe);
      drive(0, 2'($urandom_range(0, 3)), 1);
      hits = '0;
      k = 0;
      for (int j = 0; j < vecs[i].nsym; j++) begin
        if (vecs[i].idle) repeat ($urandom_range(0, 2)) drive(0, 2'($urandom_range(0, 3)), 0);
        drive(1, 2'($urandom_range(0, 3)), 0);
        if (k < 32) hits[k] = (err_o != 2'b00);
        k++;
      end
      check($sformatf("v%0d_bit_ct", i), 32'(bit_err_ct_o), 32'(vecs[i].exp_bit));
      check($sformatf("v%0d_sym_ct", i), 32'(sym_err_ct_o), 32'(vecs[i].exp_sym));
      check($sformatf("v%0d_budget", i), 32'(budget_o), 32'(vecs[i].exp_budget));
      if (vecs[i].chk_hits) check($sformatf("v%0d_hits", i), hits, vecs[i].exp_hits);
    end

    // RANDOM, threshold at maximum
    set_ctl(2'd2, 8'd0, 4'd0, 2'b11, 8'hFF, 16'd0);
    drive(0, 2'd0, 1);
    for (int j = 0; j < 1024; j++) drive(1, 2'($urandom_range(0, 3)), 0);
    check("rand_ff_range", 32'((sym_err_ct_o >= 16'd1000) && (sym_err_ct_o <= 16'd1024)), 32'd1);
    check("rand_ff_bits", 32'(bit_err_ct_o), 32'(2 * m_sym));

    // clear mid-burst with a coincident valid symbol
    set_ctl(2'd1, 8'd2, 4'd3, 2'b11, 8'd0, 16'd0);
    drive(0, 2'd0, 1);
    for (int j = 0; j < 4; j++) drive(1, 2'($urandom_range(0, 3)), 0);
    check("clr_pre_err", 32'(err_o), 32'd3);
    check("clr_pre_sym_ct", 32'(sym_err_ct_o), 32'd2);
    drive(1, 2'b10, 1);
    check("clr_err", 32'(err_o), 32'd0);
    check("clr_valid", 32'(valid_o), 32'd1);
    check("clr_sym", 32'(sym_o), 32'b10);
    check("clr_sym_ct", 32'(sym_err_ct_o), 32'd0);
    check("clr_bit_ct", 32'(bit_err_ct_o), 32'd0);
    check("clr_state", 32'(dbg_state_o), 32'(S_GAP));
    drive(1, 2'b01, 0);
    check("clr_gap0", 32'(err_o), 32'd0);
    drive(1, 2'b01, 0);
    check("clr_gap1", 32'(err_o), 32'd0);
    drive(1, 2'b01, 0);
    check("clr_burst_err", 32'(err_o), 32'd3);
    check("clr_burst_sym", 32'(sym_o), 32'b10);
    check("clr_burst_ct", 32'(sym_err_ct_o), 32'd1);

    // counter saturation on the 4-bit instance
    set_ctl(2'd1, 8'd0, 4'd1, 2'b11, 8'd0, 16'd0);
    drive(0, 2'd0, 1);
    for (int j = 0; j < 8; j++) drive(1, 2'($urandom_range(0, 3)), 0);
    check("sat_bit_8", 32'(s_bit_ct), 32'd15);
    check("sat_sym_8", 32'(s_sym_ct), 32'd8);
    for (int j = 0; j < 12; j++) drive(1, 2'($urandom_range(0, 3)), 0);
    check("sat_bit_20", 32'(s_bit_ct), 32'd15);
    check("sat_sym_20", 32'(s_sym_ct), 32'd15);
    check("wide_bit_20", 32'(bit_err_ct_o), 32'd40);
    check("wide_sym_20", 32'(sym_err_ct_o), 32'd20);

    // randomized segments against the reference model
    for (int seg = 0; seg < 12; seg++) begin
      set_ctl(2'($urandom_range(0, 3)), 8'($urandom_range(0, 6)), 4'($urandom_range(0, 5)),
              2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 20)) : 16'd0);
      drive(0, 2'd0, 1);
      for (int j = 0; j < 50; j++) begin
        if ($urandom_range(0, 29) == 0) mode_i = 2'($urandom_range(0, 3));
        drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 39) == 0);
      end
    end

    // reset asserted mid-stream
    set_ctl(2'd1, 8'd0, 4'd1, 2'b11, 8'd0, 16'd0);
    drive(0, 2'd0, 1);
    for (int j = 0; j < 3; j++) drive(1, 2'($urandom_range(0, 3)), 0);
    valid_i = 1; sym_i = 2'b11;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_sym", 32'(sym_o), 32'd0);
    check("mid_rst_err", 32'(err_o), 32'd0);
    check("mid_rst_bit_ct", 32'(bit_err_ct_o), 32'd0);
    check("mid_rst_sym_ct", 32'(sym_err_ct_o), 32'd0);
    check("mid_rst_budget", 32'(budget_o), 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_hold_valid", 32'(valid_o), 32'd0);
    rst = 1'b1;
    model_reset();
    exp_q.delete();
    drive(1, 2'b00, 0);
    check("post_rst_err", 32'(err_o), 32'd3);
    drive(0, 2'b00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: run did not complete within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
